// File: rtl/sysctrl_wb.sv
// sysctrl_wb -- Wishbone-slave system-control register block.
//
// Holds five 1-bit routing/selection controls:
//   - two clock-monitor output enables
//   - the trap output enable
//   - two IRQ input-source selects
// These drive the pad and IRQ muxing logic of the management SoC.
//
// Register map (byte offsets from BASE_ADR, bit 0 only):
//   CLK1_OUT 0x00, CLK2_OUT 0x04, TRAP_OUT 0x08, IRQ7_SRC 0x0C, IRQ8_SRC 0x10
//
// Build option:
//   SYSCTRL_IRQ_SRC_EN
//     defined     : IRQ7_SRC/IRQ8_SRC registers are implemented.
//     not defined : those offsets read 0 and ignore writes, and both IRQ
//                   select outputs are tied to 0.
//
// Ports:
//   wb_clk_i          system clock, rising edge
//   wb_rst_i          asynchronous active-low reset
//   wb_stb_i/cyc_i    Wishbone strobe / cycle
//   wb_we_i           1 = write, 0 = read
//   wb_sel_i          byte lanes; only lane 0 gates writes
//   wb_dat_i          write data (bit 0 used)
//   wb_adr_i          byte address
//   wb_ack_o          single-cycle registered acknowledge
//   wb_dat_o          registered read data, held until the next read
//   clk1_output_dest  CLK1 output-destination control
//   clk2_output_dest  CLK2 output-destination control
//   trap_output_dest  trap output-destination control
//   irq_7_inputsrc    IRQ7 input-source select
//   irq_8_inputsrc    IRQ8 input-source select

module sysctrl_wb #(
  parameter logic [31:0] BASE_ADR = 32'h2F00_0000,
  parameter logic [7:0]  CLK1_OUT = 8'h00,
  parameter logic [7:0]  CLK2_OUT = 8'h04,
  parameter logic [7:0]  TRAP_OUT = 8'h08,
  parameter logic [7:0]  IRQ7_SRC = 8'h0C,
  parameter logic [7:0]  IRQ8_SRC = 8'h10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  input  logic [31:0] wb_adr_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        clk1_output_dest,
  output logic        clk2_output_dest,
  output logic        trap_output_dest,
  output logic        irq_7_inputsrc,
  output logic        irq_8_inputsrc
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        clk1_q, clk1_d;
  logic        clk2_q, clk2_d;
  logic        trap_q, trap_d;
`ifdef SYSCTRL_IRQ_SRC_EN
  logic        irq7_q, irq7_d;
  logic        irq8_q, irq8_d;
`endif

  logic        valid;
  logic        accept;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  offset;
  logic        rd_bit;

  // Only bit 0 of the data and lane 0 of the byte enables carry meaning.
  logic        unused_inputs;
  assign unused_inputs = ^{wb_sel_i[3:1], wb_dat_i[31:1]};

  assign valid  = wb_stb_i & wb_cyc_i & (wb_adr_i[31:8] == BASE_ADR[31:8]);
  // The ~ack term makes the cycle in which ack is high a dead cycle, so a
  // master that keeps strobing sees a fresh transfer every second cycle.
  assign accept = valid & ~ack_q;
  assign wr_en  = accept & wb_we_i & wb_sel_i[0];
  assign rd_en  = accept & ~wb_we_i;
  assign offset = wb_adr_i[7:0];

  // Read mux: full-byte decode, so misaligned offsets fall into default.
  always_comb begin
    rd_bit = 1'b0;
    case (offset)
      CLK1_OUT: rd_bit = clk1_q;
      CLK2_OUT: rd_bit = clk2_q;
      TRAP_OUT: rd_bit = trap_q;
`ifdef SYSCTRL_IRQ_SRC_EN
      IRQ7_SRC: rd_bit = irq7_q;
      IRQ8_SRC: rd_bit = irq8_q;
`endif
      default:  rd_bit = 1'b0;
    endcase
  end

  always_comb begin
    clk1_d = clk1_q;
    clk2_d = clk2_q;
    trap_d = trap_q;
`ifdef SYSCTRL_IRQ_SRC_EN
    irq7_d = irq7_q;
    irq8_d = irq8_q;
`endif
    if (wr_en) begin
      case (offset)
        CLK1_OUT: clk1_d = wb_dat_i[0];
        CLK2_OUT: clk2_d = wb_dat_i[0];
        TRAP_OUT: trap_d = wb_dat_i[0];
`ifdef SYSCTRL_IRQ_SRC_EN
        IRQ7_SRC: irq7_d = wb_dat_i[0];
        IRQ8_SRC: irq8_d = wb_dat_i[0];
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    ack_d = accept;
    dat_d = dat_q;
    if (rd_en) begin
      dat_d = {31'b0, rd_bit};
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ack_q  <= 1'b0;
      dat_q  <= 32'h0;
      clk1_q <= 1'b0;
      clk2_q <= 1'b0;
      trap_q <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      clk1_q <= clk1_d;
      clk2_q <= clk2_d;
      trap_q <= trap_d;
    end
  end

`ifdef SYSCTRL_IRQ_SRC_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      irq7_q <= 1'b0;
      irq8_q <= 1'b0;
    end else begin
      irq7_q <= irq7_d;
      irq8_q <= irq8_d;
    end
  end

  assign irq_7_inputsrc = irq7_q;
  assign irq_8_inputsrc = irq8_q;
`else
  assign irq_7_inputsrc = 1'b0;
  assign irq_8_inputsrc = 1'b0;
`endif

  assign wb_ack_o         = ack_q;
  assign wb_dat_o         = dat_q;
  assign clk1_output_dest = clk1_q;
  assign clk2_output_dest = clk2_q;
  assign trap_output_dest = trap_q;

endmodule

// File: tb/tb_sysctrl_wb.sv
// Testbench for sysctrl_wb: directed scenarios followed by random Wishbone
// transfers, compared against a register-array model of the block.

module tb_sysctrl_wb;

`ifdef SYSCTRL_IRQ_SRC_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam logic [31:0] BASE = 32'h2F00_0000;

  logic        clk_sys = 1'b0;
  logic        rst_b;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_w, adr;
  logic        ack;
  logic [31:0] dat_r;
  logic        clk1_o, clk2_o, trap_o, irq7_o, irq8_o;

  int checks = 0;
  int errors = 0;

  // Model state: one bit per control, indexed by offset/4, plus held read data.
  bit          model_reg [5];
  logic [31:0] model_rd;

  always #5 clk_sys = ~clk_sys;

  sysctrl_wb dut (
    .wb_clk_i         (clk_sys),
    .wb_rst_i         (rst_b),
    .wb_stb_i         (stb),
    .wb_cyc_i         (cyc),
    .wb_we_i          (we),
    .wb_sel_i         (sel),
    .wb_dat_i         (dat_w),
    .wb_adr_i         (adr),
    .wb_ack_o         (ack),
    .wb_dat_o         (dat_r),
    .clk1_output_dest (clk1_o),
    .clk2_output_dest (clk2_o),
    .trap_output_dest (trap_o),
    .irq_7_inputsrc   (irq7_o),
    .irq_8_inputsrc   (irq8_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // -2: address outside the block (never acked); -1: acked but unmapped.
  function automatic int reg_index(input logic [31:0] a);
    if (a[31:8] != BASE[31:8]) return -2;
    case (a[7:0])
      8'h00:   return 0;
      8'h04:   return 1;
      8'h08:   return 2;
      8'h0C:   return IRQ_EN ? 3 : -1;
      8'h10:   return IRQ_EN ? 4 : -1;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) model_reg[i] = 1'b0;
    model_rd = 32'h0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".clk1"}, {31'b0, clk1_o}, {31'b0, model_reg[0]});
    chk({tag, ".clk2"}, {31'b0, clk2_o}, {31'b0, model_reg[1]});
    chk({tag, ".trap"}, {31'b0, trap_o}, {31'b0, model_reg[2]});
    chk({tag, ".irq7"}, {31'b0, irq7_o}, {31'b0, model_reg[3]});
    chk({tag, ".irq8"}, {31'b0, irq8_o}, {31'b0, model_reg[4]});
  endtask

  task automatic bus_idle();
    stb   = 1'b0;
    cyc   = 1'b0;
    we    = 1'b0;
    sel   = 4'h0;
    dat_w = 32'h0;
    adr   = 32'h0;
  endtask

  // One complete transfer; inputs change and outputs are sampled on negedges.
  task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    int idx;
    int waited;
    idx = reg_index(a);
    @(negedge clk_sys);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    waited = 0;
    do begin
      @(negedge clk_sys);
      waited++;
    end while (!ack && waited < 10);
    if (idx == -2) begin
      chk({tag, ".no_ack"}, {31'b0, ack}, 32'h0);
      bus_idle();
      return;
    end
    if (w && s[0] && idx >= 0) model_reg[idx] = d[0];
    if (!w) model_rd = (idx >= 0) ? {31'b0, model_reg[idx]} : 32'h0;
    chk({tag, ".ack_latency"}, waited, 1);
    chk_outputs(tag);
    chk({tag, ".dat"}, dat_r, model_rd);
    bus_idle();
    @(negedge clk_sys);
    chk({tag, ".ack_drop"}, {31'b0, ack}, 32'h0);
    chk({tag, ".dat_hold"}, dat_r, model_rd);
  endtask

  logic [7:0]  offs [8];
  logic [31:0] a_rnd;

  initial begin
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h40, 8'h01, 8'h0E};
    bus_idle();
    rst_b = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_sys);
    chk("reset.ack", {31'b0, ack}, 32'h0);
    chk("reset.dat", dat_r, 32'h0);
    chk_outputs("reset");
    rst_b = 1'b1;

    for (int i = 0; i < 5; i++) xfer("rd_reset", 1'b0, BASE | {24'h0, offs[i]}, 32'h0, 4'hF);

    for (int i = 0; i < 5; i++) xfer("wr_one", 1'b1, BASE | {24'h0, offs[i]}, 32'h1, 4'hF);
    for (int i = 0; i < 5; i++) xfer("rd_one", 1'b0, BASE | {24'h0, offs[i]}, 32'h0, 4'hF);

    xfer("wr_fffe", 1'b1, BASE | 32'h04, 32'hFFFF_FFFE, 4'hF);
    xfer("rd_fffe", 1'b0, BASE | 32'h04, 32'h0, 4'hF);

    xfer("wr_sel_e", 1'b1, BASE | 32'h08, 32'h0, 4'hE);
    xfer("rd_sel_e", 1'b0, BASE | 32'h08, 32'h0, 4'hF);

    xfer("foreign", 1'b1, 32'h3000_0000, 32'h0, 4'hF);
    xfer("foreign_rd", 1'b0, 32'h3000_0000, 32'h0, 4'hF);
    xfer("unmapped", 1'b0, BASE | 32'h40, 32'h0, 4'hF);
    xfer("misalign", 1'b0, BASE | 32'h01, 32'h0, 4'hF);

    // Master holding strobe: a new transfer every second cycle.
    @(negedge clk_sys);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE; dat_w = 32'h0; sel = 4'h1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      chk("stream.ack", {31'b0, ack}, (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    model_reg[0] = 1'b0;
    bus_idle();
    @(negedge clk_sys);
    chk_outputs("stream");

    // Random transfers.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0)
        a_rnd = {$urandom_range(0, 1) ? 24'h300000 : 24'h2F0001, offs[$urandom_range(0, 7)]};
      else
        a_rnd = BASE | {24'h0, offs[$urandom_range(0, 7)]};
      xfer("rand", 1'($urandom_range(0, 1)), a_rnd, $urandom,
           4'($urandom_range(0, 15)));
    end

    // Reset in the middle of a write: no ack, everything cleared at once.
    xfer("pre_rst0", 1'b1, BASE | 32'h00, 32'h1, 4'h1);
    xfer("pre_rst1", 1'b1, BASE | 32'h04, 32'h1, 4'h1);
    xfer("pre_rst2", 1'b0, BASE | 32'h04, 32'h0, 4'h1);
    @(negedge clk_sys);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE | 32'h08; dat_w = 32'h1; sel = 4'hF;
    #2 rst_b = 1'b0;
    model_reset();
    #1;
    chk_outputs("rst_async");
    chk("rst_async.dat", dat_r, 32'h0);
    repeat (3) begin
      @(negedge clk_sys);
      chk("rst_mid.ack", {31'b0, ack}, 32'h0);
    end
    chk_outputs("rst_mid");
    bus_idle();
    rst_b = 1'b1;
    @(negedge clk_sys);
    chk("rst_after.ack", {31'b0, ack}, 32'h0);
    xfer("post_rst", 1'b0, BASE | 32'h08, 32'h0, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
